key_conditioner: RTL and testbench

//  Front end for the stopwatch control FSM: turns one raw board push-button into the
//  two control inputs that FSM consumes: a single-cycle key pulse (start/stop toggle)
//  and a hold level (clear). Synchronises, debounces and times the press, so a short

---
 rtl/key_conditioner.sv | 139 +++++++++++++
 tb/tb_key_conditioner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Push-button conditioner: 2-flop sync, debounce, short-press pulse (o_key) and long-press hold (o_delay).
// Latency: pin edge to o_pressed/o_key/o_delay-fall is DEBOUNCE_CYCLES+3 clocks; no backpressure, all outputs registered.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 100000000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_raw,
  output logic o_key,
  output logic o_delay,
  output logic o_pressed
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
  // Raw pin level when the button is not pressed.
  localparam logic RELEASED = KEY_ACTIVE_LOW;

  generate
    if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2) begin : g_param_check
      $error("key_conditioner: DEBOUNCE_CYCLES and HOLD_CYCLES must be >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    HELD,
    DB_REL
  } state_t;

  state_t          state, state_nxt;
  logic            sync1, sync2, key_s;
  logic [DW-1:0]   dcnt, dcnt_nxt;
  logic [HW-1:0]   hcnt, hcnt_nxt;
  logic            short_q, short_nxt;
  logic            key_nxt, delay_nxt, pressed_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= RELEASED;
      sync2 <= RELEASED;
    end else begin
      sync1 <= i_key_raw;
      sync2 <= sync1;
    end
  end

  assign key_s = sync2 ^ RELEASED;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      dcnt      <= '0;
      hcnt      <= '0;
      short_q   <= 1'b0;
      o_key     <= 1'b0;
      o_delay   <= 1'b0;
      o_pressed <= 1'b0;
    end else begin
      state     <= state_nxt;
      dcnt      <= dcnt_nxt;
      hcnt      <= hcnt_nxt;
      short_q   <= short_nxt;
      o_key     <= key_nxt;
      o_delay   <= delay_nxt;
      o_pressed <= pressed_nxt;
    end
  end

  // Counters only advance below their terminal value, so they can never wrap.
  always_comb begin
    state_nxt   = state;
    dcnt_nxt    = dcnt;
    hcnt_nxt    = hcnt;
    short_nxt   = short_q;
    key_nxt     = 1'b0;
    delay_nxt   = o_delay;
    pressed_nxt = o_pressed;
    case (state)
      IDLE: begin
        if (key_s) begin
          state_nxt = DB_PRESS;
          dcnt_nxt  = '0;
        end
      end
      DB_PRESS: begin
        if (!key_s) begin
          state_nxt = IDLE;
        end else if (dcnt == D_LAST) begin
          state_nxt   = PRESSED;
          hcnt_nxt    = '0;
          pressed_nxt = 1'b1;
        end else begin
          dcnt_nxt = dcnt + 1'b1;
        end
      end
      PRESSED: begin
        // Release is checked first so a release on the terminal hold count stays short.
        if (!key_s) begin
          state_nxt = DB_REL;
          short_nxt = 1'b1;
          dcnt_nxt  = '0;
        end else if (hcnt == H_LAST) begin
          state_nxt = HELD;
          delay_nxt = 1'b1;
        end else begin
          hcnt_nxt = hcnt + 1'b1;
        end
      end
      HELD: begin
        if (!key_s) begin
          state_nxt = DB_REL;
          short_nxt = 1'b0;
          dcnt_nxt  = '0;
        end
      end
      DB_REL: begin
        if (key_s) begin
          state_nxt = short_q ? PRESSED : HELD;
        end else if (dcnt == D_LAST) begin
          state_nxt   = IDLE;
          pressed_nxt = 1'b0;
          delay_nxt   = 1'b0;
          key_nxt     = short_q;
        end else begin
          dcnt_nxt = dcnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: active-low and active-high instances share one pressed/released
// waveform; a timing-level reference model feeds per-instance event queues checked by a monitor.
module tb_key_conditioner;
  localparam int D = 4;
  localparam int H = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic pin_lo, pin_hi;
  logic key0, del0, prs0, key1, del1, prs1;

  always #5 clk = ~clk;

  key_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .KEY_ACTIVE_LOW(1'b1)) dut_lo (
    .i_clk(clk), .i_rst_n(rst_n), .i_key_raw(pin_lo),
    .o_key(key0), .o_delay(del0), .o_pressed(prs0)
  );

  key_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .KEY_ACTIVE_LOW(1'b0)) dut_hi (
    .i_clk(clk), .i_rst_n(rst_n), .i_key_raw(pin_hi),
    .o_key(key1), .o_delay(del1), .o_pressed(prs1)
  );

  typedef struct packed {
    int   cyc;
    logic p;
    logic d;
    logic k;
  } ev_t;

  ev_t q_lo[$];
  ev_t q_hi[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  bit  cur_press = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: the pin is seen two clocks late; a new level is accepted after D+1
  // consecutive samples; press time counts clocks spent pressed with no release pending.
  bit m_deb, m_held, m_d1, m_d2, m_last, e_p, e_d;
  int m_run, m_hc;

  function automatic void model_reset();
    m_deb = 0; m_held = 0; m_d1 = 0; m_d2 = 0; m_last = 0;
    e_p = 0; e_d = 0; m_run = 0; m_hc = 0;
  endfunction

  task automatic model_step(input bit press);
    bit ks;
    bit key;
    ev_t e;
    ks   = m_d2;
    m_d2 = m_d1;
    m_d1 = press;
    key  = 1'b0;
    if (m_deb && ks && m_last && !m_held) begin
      m_hc++;
      if (m_hc == H) m_held = 1'b1;
    end
    if (ks != m_deb) begin
      m_run++;
      if (m_run == D + 1) begin
        m_run = 0;
        if (m_deb) begin
          key    = !m_held;
          m_held = 1'b0;
          m_deb  = 1'b0;
        end else begin
          m_deb  = 1'b1;
          m_hc   = 0;
          m_held = 1'b0;
        end
      end
    end else begin
      m_run = 0;
    end
    m_last = ks;
    if (key || m_deb != e_p || m_held != e_d) begin
      e.cyc = cyc; e.p = m_deb; e.d = m_held; e.k = key;
      q_lo.push_back(e);
      q_hi.push_back(e);
    end
    e_p = m_deb;
    e_d = m_held;
  endtask

  task automatic drive(input bit press, input int n);
    repeat (n) begin
      @(negedge clk);
      cur_press = press;
      pin_lo = ~press;
      pin_hi = press;
      @(posedge clk);
      if (rst_n) model_step(press);
    end
  endtask

  task automatic check_ev(input int inst, input int c, input logic p, input logic d, input logic k);
    ev_t e;
    n_checks++;
    if ((inst == 0 && q_lo.size() == 0) || (inst == 1 && q_hi.size() == 0)) begin
      n_fail++;
      $display("FAIL unexpected_event inst%0d: got cyc=%0d p=%0b d=%0b k=%0b, expected no event",
               inst, c, p, d, k);
    end else begin
      e = (inst == 0) ? q_lo.pop_front() : q_hi.pop_front();
      if (e.cyc != c || e.p != p || e.d != d || e.k != k) begin
        n_fail++;
        $display("FAIL output_event inst%0d: got cyc=%0d p=%0b d=%0b k=%0b, expected cyc=%0d p=%0b d=%0b k=%0b",
                 inst, c, p, d, k, e.cyc, e.p, e.d, e.k);
      end
    end
  endtask

  task automatic check_outs(input string name, input logic [2:0] got, input logic [2:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {p,d,k}=%b, expected %b", name, got, exp);
    end
  endtask

  initial begin : monitor
    bit pp0, pd0, pp1, pd1;
    pp0 = 0; pd0 = 0; pp1 = 0; pd1 = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pp0 = 0; pd0 = 0; pp1 = 0; pd1 = 0;
        continue;
      end
      n_checks++;
      if ((key0 && del0) || (key1 && del1)) begin
        n_fail++;
        $display("FAIL key_delay_overlap: got key0=%0b del0=%0b key1=%0b del1=%0b, expected never both high",
                 key0, del0, key1, del1);
      end
      if (key0 || prs0 != pp0 || del0 != pd0) check_ev(0, cyc - 1, prs0, del0, key0);
      if (key1 || prs1 != pp1 || del1 != pd1) check_ev(1, cyc - 1, prs1, del1, key1);
      pp0 = prs0; pd0 = del0; pp1 = prs1; pd1 = del1;
    end
  end

  initial begin : stimulus
    int len;
    bit lvl;
    rst_n  = 1'b0;
    pin_lo = 1'b1;
    pin_hi = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outs("reset_state_lo", {prs0, del0, key0}, 3'b000);
    check_outs("reset_state_hi", {prs1, del1, key1}, 3'b000);
    rst_n = 1'b1;
    @(posedge clk);
    model_step(cur_press);

    // short press
    drive(0, 5);  drive(1, 10); drive(0, 15);
    // long press
    drive(1, 40); drive(0, 15);
    // press bounce only
    drive(1, 2);  drive(0, 1);  drive(1, 2);  drive(0, 15);
    // release bounce inside a short press, then one that runs past the hold time
    drive(1, 10); drive(0, 2);  drive(1, 5);  drive(0, 15);
    drive(1, 12); drive(0, 2);  drive(1, 14); drive(0, 15);

    // async reset while held, pin kept pressed through and after reset
    drive(1, 40);
    #1;
    check_outs("held_before_reset", {prs0, del0, key0}, 3'b110);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outs("async_reset_lo", {prs0, del0, key0}, 3'b000);
    check_outs("async_reset_hi", {prs1, del1, key1}, 3'b000);
    drive(1, 3);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_step(cur_press);
    drive(1, 12); drive(0, 15);

    lvl = 1'b0;
    repeat (80) begin
      lvl = ~lvl;
      case ($urandom_range(0, 2))
        0:       len = $urandom_range(1, 3);
        1:       len = $urandom_range(4, 14);
        default: len = $urandom_range(18, 35);
      endcase
      drive(lvl, len);
    end
    drive(0, 20);

    n_checks++;
    if (q_lo.size() != 0 || q_hi.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: got %0d/%0d events outstanding, expected 0/0",
               q_lo.size(), q_hi.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
